// File: rtl/uart_tx.sv
// uart_tx: start + 8 data bits (LSB first) + STOP_BITS stop bits, each CLKS_PER_BIT clocks,
// with a single-entry holding register so queued bytes go out back-to-back.
module uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 2
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, hold_q;
  logic          stop_q, stop_d, hold_full_q, hold_full_d;
  logic          tx_q, tx_d, done_q, done_d, busy_q;
  logic          accept, load, bit_end, stop_end;
  assign accept   = tx_valid & ~hold_full_q;
  assign bit_end  = cnt_q == LAST;
  assign stop_end = bit_end & ((STOP_BITS == 1) | stop_q);
  assign tx_ready = ~hold_full_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE:  load = hold_full_q;
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          tx_d    = shift_q[1];
        end
      end
      STOP: if (bit_end) begin
        stop_d = ~stop_q;
        if (stop_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
          load    = hold_full_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // a queued byte goes straight into START, even from the last stop cycle
    if (load) begin
      state_d = START;
      shift_d = hold_q;
      tx_d    = 1'b0;
    end
    hold_full_d = accept | (hold_full_q & ~load);
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= accept ? tx_data : hold_q;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      busy_q      <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; stimulus queues expected bytes, a serial monitor decodes frames and checks them.
module tb_uart_tx;
  logic clk = 1'b0, reset_ = 1'b0, tx_valid = 1'b0, sel = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic ready_a, tx_a, busy_a, done_a, ready_b, tx_b, busy_b, done_b;
  logic m_tx, m_ready, m_busy, m_done;
  logic mon_busy = 1'b0, abort = 1'b0;
  int cyc = 0, n_chk = 0, n_fail = 0, n_done = 0, cpb = 8, nstop = 2;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx dut_a (.clk(clk), .reset_(reset_), .tx_data(tx_data), .tx_valid(tx_valid & ~sel),
                 .tx_ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));
  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_b (.clk(clk), .reset_(reset_), .tx_data(tx_data),
                 .tx_valid(tx_valid & sel), .tx_ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  assign m_tx    = sel ? tx_b : tx_a;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) n_done <= n_done + int'(done_a) + int'(done_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!reset_) abort = 1'b1;
    end
  endtask

  // Monitor: acts as the receiver, sampling mid-bit and checking done/busy at frame end.
  initial begin : mon
    logic [7:0] b, e;
    int s, c, ns;
    logic pend;
    pend = 1'b0;
    forever begin
      if (!pend) @(negedge clk);
      pend = 1'b0;
      if (reset_ && m_tx === 1'b0) begin
        mon_busy = 1'b1;
        abort = 1'b0;
        s = cyc; c = cpb; ns = nstop;
        starts.push_back(s);
        chk("busy_at_start", 32'(m_busy), 1);
        wait_n(c / 2);
        if (!abort) chk("start_bit", 32'(m_tx), 0);
        for (int i = 0; i < 8; i++) begin
          wait_n(c);
          b[i] = m_tx;
        end
        for (int i = 0; i < ns; i++) begin
          wait_n(c);
          if (!abort) chk("stop_bit", 32'(m_tx), 1);
        end
        wait_n(c / 2 - 1);
        if (!abort) chk("done_early", 32'(m_done), 0);
        wait_n(1);
        if (!abort) begin
          chk("done_pulse", 32'(m_done), 1);
          chk("busy_end", 32'(m_busy), 32'(!m_tx));
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL frame_data: got %02h with nothing expected", b);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", 32'(b), 32'(e));
          end
          pend = (m_tx === 1'b0);
        end
        mon_busy = pend;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit exp_it, output int acc);
    int n;
    n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (m_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: tx_ready stayed 0, expected 1");
    end else if (exp_it) exp_q.push_back(b);
    @(negedge clk);
    acc = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d frames pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, lowcnt, sz;
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", 32'({m_tx, m_ready, m_busy, m_done}), 32'b1100);
    end
    send(8'hA5, 1'b1, acc);
    drain();
    chk("a5_start_latency", starts[starts.size()-1], acc + 1);
    send(8'h00, 1'b1, acc);
    send(8'hFF, 1'b1, acc2);
    tx_data = 8'h77;
    tx_valid = 1'b1;
    lowcnt = 0;
    while (m_ready !== 1'b1 && lowcnt < 200) begin
      lowcnt++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("b2b_ready_low_cycles", lowcnt, 87);
    drain();
    sz = starts.size();
    chk("b2b_first_start", starts[sz-2], acc + 1);
    chk("b2b_spacing", starts[sz-1] - starts[sz-2], 88);
    send(8'h3C, 1'b1, acc);
    send(8'h81, 1'b1, acc);
    send(8'h00, 1'b1, acc);
    drain();
    sel = 1'b1; cpb = 4; nstop = 1;
    @(negedge clk);
    send(8'hC3, 1'b1, acc);
    drain();
    chk("c3_start_latency", starts[starts.size()-1], acc + 1);
    sel = 1'b0; cpb = 8; nstop = 2;
    @(negedge clk);
    send(8'h55, 1'b0, acc);
    send(8'hAA, 1'b0, acc2);
    while (cyc < acc + 1 + 40 + 3) @(negedge clk);
    #2 reset_ = 1'b0;
    #1 chk("reset_async", 32'({m_tx, m_ready, m_busy, m_done}), 32'b1100);
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'({m_tx, m_ready, m_busy, m_done}), 32'b1100);
    end
    chk("done_count", n_done, 7);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that converts parallel bytes into asynchronous frames on a single idle-high line: one start bit (0), 8 data bits LSB first, then STOP_BITS stop bits (1). Each bit is held for CLKS_PER_BIT clock cycles. The default frame (2 stop bits, 8 clocks/bit) is exactly what the clock design's UART receiver decodes, so the block can drive the receiver directly for loopback and status output. A single-entry holding register lets the producer queue the next byte while the current frame is shifting, so back-to-back frames leave no idle gap.

## Interface
- CLKS_PER_BIT, 8: clock cycles per bit period; legal range 2..256.
- STOP_BITS, 2: number of stop bits; legal values are 1 or 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_  in  1  reset; asynchronous, active-low.
- tx_data  in  8  byte to send; sampled only on accept.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_ready  out  1  holding register empty; accept = tx_valid & tx_ready at a rising edge.
- tx  out  1  serial line; registered output; idles at 1.
- busy  out  1  a frame is on the line (state != IDLE).
- done  out  1  one-cycle pulse after the last stop bit of each frame.

## Operation
- **Reset values:** tx=1, tx_ready=1, busy=0, done=0. State=IDLE, hold register empty, all counters 0.
- **Holding register (hold_data, hold_full):**
  - Accept sets hold_full and captures tx_data.
  - tx_ready = ~hold_full (combinational from the flop).
  - tx_valid is ignored while tx_ready=0.
  - Holding register empties at the edge where its byte is loaded into the shift register.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** tx=1. If hold_full, load shift_reg from hold_data, clear hold_full, go to START, drive tx=0.
- **START:** tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0 and tx=shift_reg[0].
- **DATA:**
  - Each bit is held CLKS_PER_BIT cycles.
  - At the end of a bit period, shift right and increment bit_idx.
  - After bit_idx=7 completes, go to STOP with tx=1.
- **STOP:**
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end: done=1 for the next cycle.
  - If hold_full, load the next byte and go directly to START (tx=0 immediately, no idle cycle). Otherwise go to IDLE.
- **Counters:**
  - Bit-period counter width is $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1 and wrapping.
  - bit_idx is 3 bits; stop counter is 1 bit.
  - No arithmetic overflow is possible within legal parameters.
- **Simultaneous events:**
  - Accept and hold-to-shift load can never occur on the same edge, because loading requires hold_full=1, which forces tx_ready=0.
  - An accept during any state (including the final stop cycle) fills the holding register only.
- **Reset mid-frame:** tx returns to 1 asynchronously; the frame is truncated; the held byte is discarded; done does not pulse.

## Timing
- **Accept to start bit:** accept at edge k (idle, hold empty) → hold_full set at k, tx=0 from edge k+1. Latency is 1 cycle.
- **tx_ready timing:** low for exactly one cycle (k to k+1) when idle; it reasserts at k+1.
- **Frame length:** (9+STOP_BITS)*CLKS_PER_BIT cycles; default 88 cycles.
- **done:** high for the single cycle beginning at edge k+1+frame_len.
- **busy:** high from edge k+1 through edge k+1+frame_len. It stays high across back-to-back frames.
- **Back-to-back spacing:** start bits of consecutive queued frames are exactly frame_len cycles apart.
- **Registered outputs:** tx, busy and done are registered with no combinational path from inputs. tx_ready depends only on hold_full.

## Test plan
- **Reset/idle:** Hold reset_ low, release, run 20 cycles → tx=1, tx_ready=1, busy=0, done=0 throughout.
- **Single byte 0xA5, defaults:** Accept at edge k → tx carries 0 (8 cycles), then bits 1,0,1,0,0,1,0,1 (8 cycles each), then 1 for 16 cycles. done pulses exactly at edge k+89; busy is high for 88 cycles.
- **Back-to-back 0x00 then 0xFF:**
  - Second byte is accepted mid-frame; tx_ready is low until the first STOP ends.
  - The second start bit begins exactly 88 cycles after the first with no gap.
  - Two done pulses arrive 88 cycles apart; tx_valid is held high during tx_ready=0 and no extra byte is taken.
- **Loopback to receiver:** Send 0x3C, 0x81, 0x00 into the receiver module → receiver presents each byte with its one-cycle valid pulse and no error state.
- **Reset mid-DATA (bit 4 of 0x55) with a byte held:** tx goes to 1 asynchronously; after release, 50 idle cycles show no start bit and no done pulse, and tx_ready=1.
- **Parameter sweep STOP_BITS=1, CLKS_PER_BIT=4:** Send 0xC3 → frame is 40 cycles with 4 stop cycles; done pulses at edge k+41.
